// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with valid/ready handshake, iterative shifts and shift-add multiply
// Ports: clk_in/rst_in clock and sync active-high reset; valid_in/ready_out accept side with
// ula_op_in, a_in, b_in operands; valid_out/ready_in result side with result_out and
// zero_out, neg_out, carry_out, ovf_out status flags.
module ula_seq #(
    parameter int BITS = 8,
    parameter int ULA_OP = 4,
    localparam int SHW = $clog2(BITS)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic [ULA_OP-1:0] ula_op_in,
    input  logic [BITS-1:0]   a_in,
    input  logic [BITS-1:0]   b_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [BITS-1:0]   result_out,
    output logic              zero_out,
    output logic              neg_out,
    output logic              carry_out,
    output logic              ovf_out
);
    localparam logic [ULA_OP-1:0] OP_NOT = ULA_OP'(0), OP_AND = ULA_OP'(1), OP_OR = ULA_OP'(2),
        OP_XOR = ULA_OP'(3), OP_ADD = ULA_OP'(4), OP_SUB = ULA_OP'(5), OP_SLL = ULA_OP'(6),
        OP_SRL = ULA_OP'(7), OP_SRA = ULA_OP'(8), OP_MUL = ULA_OP'(9), OP_MULH = ULA_OP'(10);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t state, state_nxt;
    logic [ULA_OP-1:0] op;
    logic [2*BITS-1:0] wrk, acc, acc_stp;
    logic [BITS-1:0] mplr, sh_stp, res_idle, res_d;
    logic [BITS:0] sum, dif;
    logic [SHW:0] cnt;
    logic [SHW-1:0] shamt;
    logic in_sh, in_mul, is_mul, one, accept, fin, load, c_idle, v_idle, c_d, v_d;

    assign ready_out = state == IDLE;
    assign valid_out = state == DONE;
    assign shamt = b_in[SHW-1:0];
    assign in_sh = ula_op_in >= OP_SLL && ula_op_in <= OP_SRA;
    assign in_mul = ula_op_in == OP_MUL || ula_op_in == OP_MULH;
    assign is_mul = op == OP_MUL || op == OP_MULH;
    // single-cycle unless it needs the iterative datapath
    assign one = !in_mul && !(in_sh && shamt != '0);
    assign accept = valid_in && state == IDLE;
    // last EXEC step: its result is written on the same edge that enters DONE
    assign fin = state == EXEC && cnt == CNT_ONE;
    assign load = (accept && one) || fin;

    always_comb begin
        sum = {1'b0, a_in} + {1'b0, b_in};
        dif = {1'b0, a_in} - {1'b0, b_in};
        res_idle = '0;
        c_idle = 1'b0;
        v_idle = 1'b0;
        case (ula_op_in)
            OP_NOT: res_idle = ~b_in;
            OP_AND: res_idle = a_in & b_in;
            OP_OR:  res_idle = a_in | b_in;
            OP_XOR: res_idle = a_in ^ b_in;
            OP_ADD: begin
                res_idle = sum[BITS-1:0];
                c_idle = sum[BITS];
                v_idle = a_in[BITS-1] == b_in[BITS-1] && sum[BITS-1] != a_in[BITS-1];
            end
            OP_SUB: begin
                res_idle = dif[BITS-1:0];
                c_idle = dif[BITS];
                v_idle = a_in[BITS-1] != b_in[BITS-1] && dif[BITS-1] != a_in[BITS-1];
            end
            OP_SLL, OP_SRL, OP_SRA: res_idle = a_in;
            default: res_idle = '0;
        endcase
        sh_stp = op == OP_SLL ? wrk[BITS-1:0] << 1 :
                 op == OP_SRL ? wrk[BITS-1:0] >> 1 : {wrk[BITS-1], wrk[BITS-1:1]};
        acc_stp = acc + (mplr[0] ? wrk : '0);
        res_d = state == IDLE ? res_idle : !is_mul ? sh_stp :
                op == OP_MUL ? acc_stp[BITS-1:0] : acc_stp[2*BITS-1:BITS];
        c_d = state == IDLE && c_idle;
        v_d = state == IDLE ? v_idle : op == OP_MUL && |acc_stp[2*BITS-1:BITS];
        state_nxt = state == IDLE ? (valid_in ? (one ? DONE : EXEC) : IDLE) :
                    state == EXEC ? (cnt == CNT_ONE ? DONE : EXEC) :
                    (ready_in ? IDLE : DONE);
    end

    always_ff @(posedge clk_in)
        state <= rst_in ? IDLE : state_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            op <= '0;
            wrk <= '0;
            acc <= '0;
            mplr <= '0;
            cnt <= '0;
            result_out <= '0;
            zero_out <= 1'b0;
            neg_out <= 1'b0;
            carry_out <= 1'b0;
            ovf_out <= 1'b0;
        end else begin
            if (accept) begin
                op <= ula_op_in;
                wrk <= {{BITS{1'b0}}, a_in};
                mplr <= b_in;
                acc <= '0;
                cnt <= in_mul ? (SHW+1)'(BITS) : {1'b0, shamt};
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_ONE;
                wrk <= is_mul ? wrk << 1 : {{BITS{1'b0}}, sh_stp};
                mplr <= mplr >> 1;
                acc <= acc_stp;
            end
            if (load) begin
                result_out <= res_d;
                zero_out <= res_d == '0;
                neg_out <= res_d[BITS-1];
                carry_out <= c_d;
                ovf_out <= v_d;
            end
        end
    end
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed and random checks of ula_seq against an arithmetic reference model
module tb_ula_seq;
    logic clk_in = 1'b0, rst_in, valid_in, ready_out, valid_out, ready_in;
    logic [3:0] ula_op_in;
    logic [7:0] a_in, b_in, result_out;
    logic zero_out, neg_out, carry_out, ovf_out;
    int n_chk = 0, n_fail = 0;

    ula_seq #(.BITS(8), .ULA_OP(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .ready_out(ready_out),
        .ula_op_in(ula_op_in), .a_in(a_in), .b_in(b_in), .valid_out(valid_out),
        .ready_in(ready_in), .result_out(result_out), .zero_out(zero_out),
        .neg_out(neg_out), .carry_out(carry_out), .ovf_out(ovf_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [7:0] a, b,
                                  output logic [7:0] r, output logic c, v, output int lat);
        int sh;
        logic [15:0] p;
        logic [8:0] s;
        sh = int'(b[2:0]);
        p = a * b;
        s = a + b;
        r = 8'h00;
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = ~b;
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd4: begin r = s[7:0]; c = s[8]; v = a[7] == b[7] && r[7] != a[7]; end
            4'd5: begin r = a - b; c = a < b; v = a[7] != b[7] && r[7] != a[7]; end
            4'd6: begin r = a << sh; lat = sh + 1; end
            4'd7: begin r = a >> sh; lat = sh + 1; end
            4'd8: begin r = 8'($signed(a) >>> sh); lat = sh + 1; end
            4'd9: begin r = p[7:0]; v = p[15:8] != 0; lat = 9; end
            4'd10: begin r = p[15:8]; lat = 9; end
            default: r = 8'h00;
        endcase
    endfunction

    // ready_in stays high while waiting to show early assertion has no effect
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, b, input int hold);
        logic [7:0] r;
        logic c, v;
        int lat, n;
        model(op, a, b, r, c, v, lat);
        chk("ready_before", ready_out, 1);
        ula_op_in = op; a_in = a; b_in = b; valid_in = 1'b1; ready_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0; a_in = 8'($urandom); b_in = 8'($urandom); ula_op_in = 4'($urandom);
        n = 1;
        while (!valid_out && n < 40) begin
            @(posedge clk_in); #1;
            n++;
        end
        ready_in = 1'b0;
        chk($sformatf("lat_op%0d", op), n, lat);
        chk($sformatf("res_op%0d_%h_%h", op, a, b), result_out, r);
        chk($sformatf("flags_op%0d_%h_%h", op, a, b), {zero_out, neg_out, carry_out, ovf_out},
            {r == 8'h00, r[7], c, v});
        repeat (hold) begin
            valid_in = 1'($urandom); a_in = 8'($urandom);
            @(posedge clk_in); #1;
            chk("hold_res", result_out, r);
            chk("hold_flags", {zero_out, neg_out, carry_out, ovf_out}, {r == 8'h00, r[7], c, v});
            chk("hold_hs", {ready_out, valid_out}, 2'b01);
        end
        valid_in = 1'b0; ready_in = 1'b1;
        @(posedge clk_in); #1;
        ready_in = 1'b0;
        chk("release_hs", {ready_out, valid_out}, 2'b10);
    endtask

    initial begin
        logic seen;
        rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b0; ula_op_in = '0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        chk("rst_hs", {ready_out, valid_out}, 2'b10);
        chk("rst_out", {result_out, zero_out, neg_out, carry_out, ovf_out}, 12'h000);
        run_op(4'd4, 8'h7F, 8'h01, 0);
        run_op(4'd5, 8'h10, 8'h20, 0);
        run_op(4'd4, 8'hFF, 8'h01, 0);
        run_op(4'd8, 8'h80, 8'h03, 0);
        run_op(4'd7, 8'h80, 8'h0B, 0);
        run_op(4'd6, 8'h5A, 8'h00, 0);
        run_op(4'd9, 8'h10, 8'h20, 0);
        run_op(4'd10, 8'h10, 8'h20, 0);
        run_op(4'd9, 8'hFF, 8'hFF, 0);
        run_op(4'd10, 8'hFF, 8'hFF, 0);
        run_op(4'd13, 8'h33, 8'h44, 0);
        run_op(4'd3, 8'hA5, 8'h0F, 5);
        run_op(4'd4, 8'h11, 8'h22, 0);
        // abort a multiply part-way through
        ula_op_in = 4'd9; a_in = 8'h10; b_in = 8'h20; valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("abort_hs", {ready_out, valid_out}, 2'b10);
        chk("abort_out", {result_out, zero_out, neg_out, carry_out, ovf_out}, 12'h000);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk_in); #1;
            seen |= valid_out;
        end
        chk("abort_no_valid", seen, 0);
        run_op(4'd4, 8'h02, 8'h03, 0);
        for (int i = 0; i < 200; i++)
            run_op(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Multi-cycle, parametrised successor to the combinational ULA for the REDUX-V datapath.
- Adds a valid/ready handshake on both sides, iterative shifts (one bit per cycle), an unsigned shift-add multiplier, and status flags.
- Sits between the register-file read stage and write-back.
- The control FSM stalls on ready_out low and waits for valid_out.

Parameters:
- BITS, 8, operand/result width; power of two, at least 4.
- ULA_OP, 4, opcode width.
- SHW, $clog2(BITS), shift-amount width; derived, do not override.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- valid_in  input  1  operands and opcode are valid.
- ready_out  output  1  block can accept an operation.
- ula_op_in  input  ULA_OP  operation select.
- a_in  input  BITS  operand A.
- b_in  input  BITS  operand B; shift amount is b_in[SHW-1:0].
- valid_out  output  1  result and flags are valid.
- ready_in  input  1  consumer accepts the result.
- result_out  output  BITS  result.
- zero_out  output  1  result_out == 0.
- neg_out  output  1  result_out[BITS-1].
- carry_out  output  1  ADD: carry out. SUB: borrow (a < b unsigned). Otherwise 0.
- ovf_out  output  1  ADD/SUB: signed overflow. MUL: high half nonzero. Otherwise 0.

Behaviour:
- Opcodes:
  - 0000 ~b
  - 0001 a&b
  - 0010 a|b
  - 0011 a^b
  - 0100 a+b
  - 0101 a-b
  - 0110 SLL
  - 0111 SRL
  - 1000 SRA
  - 1001 MUL: low BITS of unsigned a*b
  - 1010 MULH: high BITS of unsigned a*b
  - 1011-1111: result 0, all flags computed as for a normal result (zero_out=1).
- FSM states IDLE, EXEC, DONE.
- ready_out = (state==IDLE). valid_out = (state==DONE). Both are registered-state decodes.
- Accept: the edge where valid_in && ready_out. On that edge, a, b, op and the shift amount are latched. Inputs are don't-care afterwards.
- From IDLE on accept:
  - Logic, ADD, SUB, undefined opcodes, and shifts with amount 0: result and flags are written, next state DONE. Latency 1 cycle (valid_out high on the cycle after accept).
  - Shift with amount k>0: counter=k, next state EXEC.
    - Each EXEC cycle shifts the working register 1 bit: SLL fills 0, SRL fills 0, SRA replicates the MSB.
    - When the counter reaches 0, the FSM moves to DONE. Latency k+1.
  - MUL/MULH: 2*BITS accumulator cleared, counter=BITS, next state EXEC.
    - Each EXEC cycle: if the multiplier LSB is 1, add the shifted multiplicand; then shift.
    - After BITS steps, go to DONE. Latency BITS+1.
- DONE:
  - result_out and flags are held stable.
  - valid_in is ignored.
  - On ready_in=1, next state is IDLE.
  - No accept occurs in the DONE cycle. Throughput is at most one op per latency+1 cycles.
- ready_in asserted early (while IDLE or EXEC) has no effect.
- Flags are computed from the final result in the same edge the FSM enters DONE.
  - carry_out and ovf_out are 0 for ops not listed in their port definitions.
- Reset, synchronous, rst_in high at an edge:
  - state=IDLE; counter, working registers, result_out and all flags cleared to 0; valid_out=0.
  - ready_out=1 from the cycle after the reset edge.
  - Reset takes priority over accept.
  - Reset during EXEC or DONE aborts the op; no valid_out is produced for it.
- Width rules:
  - All arithmetic wraps modulo 2^BITS except the MUL accumulator (2*BITS).
  - ADD carry = bit BITS of the (BITS+1)-bit sum.
  - Shift amounts are limited to 0..BITS-1 by SHW truncation of b_in.

Test Plan (BITS=8):
1. ADD a=0x7F b=0x01 -> result 0x80, neg=1, ovf=1, carry=0, zero=0; valid_out exactly 1 cycle after accept.
2. SUB a=0x10 b=0x20 -> result 0xF0, carry=1, ovf=0. Then ADD 0xFF+0x01 -> result 0x00, zero=1, carry=1.
3. SRA a=0x80 b=0x03 -> result 0xF0, latency 4. SRL a=0x80 b=0x0B (amount 3) -> 0x10. SLL with b=0x00 -> result=a, latency 1.
4. MUL a=0x10 b=0x20 -> result 0x00, zero=1, ovf=1, latency 9. MULH same operands -> 0x02, ovf=0. MUL 0xFF*0xFF -> 0x01; MULH -> 0xFE.
5. Backpressure: hold ready_in=0 for 5 cycles in DONE and toggle valid_in/a_in -> result and flags stable, ready_out=0 throughout. Raise ready_in -> IDLE next cycle, new op accepted.
6. Assert rst_in 4 cycles into a MUL -> valid_out never rises, outputs 0, ready_out=1 the next cycle; a following ADD 0x02+0x03 -> 0x05 correct.
